am2914_pic: RTL and testbench

- Clocked 8-level vectored priority interrupt controller, modelled after the Am2914.
- Sits directly upstream of the am2913 expander / microsequencer vector path.
- Latches interrupt requests, applies a mask and an in-service status level, and presents the highest pending vector with an interrupt request.
- Provides ei_/eo_ cascade signals so several controllers or expanders chain by priority.

---
 rtl/am2914_pic.sv | 152 +++++++++++++++
 tb/tb_am2914_pic.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/am2914_pic.sv
// Am2914-style 8-level vectored priority interrupt controller with ei_/eo_ cascade.
// Define AM2914_EDGE_TRIG_EN for falling-edge-triggered request latching (default: level-sensitive).
module am2914_pic #(
    parameter int N  = 8,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  p_,
    input  logic [3:0]    i,
    input  logic          ie_,
    input  logic [N-1:0]  m,
    input  logic          ei_,
    output logic          eo_,
    output logic          irq_,
    output logic [VW-1:0] v,
    output logic [N-1:0]  d,
    output logic          d_oe
);

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_CLRALL  = 4'd1;
    localparam logic [3:0] OP_CLRSEL  = 4'd2;
    localparam logic [3:0] OP_CLRMSK  = 4'd3;
    localparam logic [3:0] OP_LDMSK   = 4'd4;
    localparam logic [3:0] OP_SETMSK  = 4'd5;
    localparam logic [3:0] OP_CLRBMSK = 4'd6;
    localparam logic [3:0] OP_LDSTAT  = 4'd7;
    localparam logic [3:0] OP_ACK     = 4'd8;
    localparam logic [3:0] OP_EOI     = 4'd9;
    localparam logic [3:0] OP_ENA     = 4'd10;
    localparam logic [3:0] OP_DIS     = 4'd11;
    localparam logic [3:0] OP_RDMSK   = 4'd12;
    localparam logic [3:0] OP_RDSTAT  = 4'd13;

    // Highest set bit wins; an empty input encodes as zero.
    function automatic logic [2:0] prio_enc(input logic [7:0] a);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (a[k]) begin
                r = k[2:0];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] x);
        return 8'd1 << x;
    endfunction

    logic [7:0] pend_q, pend_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] stat_q, stat_d;
    logic       ien_q, ien_d;

    logic [3:0] op_s;
    logic [7:0] act_s;
    logic [2:0] v_s;
    logic       hit_s;
    logic [7:0] clrmask_s;
    logic [7:0] set_s;
    logic [7:0] d_s;
    logic       d_oe_s;

`ifdef AM2914_EDGE_TRIG_EN
    logic [7:0] p_hist_q;

    // History of p_ so only a 1->0 transition between edges sets a latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_hist_q <= 8'hFF;
        end else begin
            p_hist_q <= p_;
        end
    end

    assign set_s = p_hist_q & ~p_;
`else
    assign set_s = ~p_;
`endif

    assign op_s  = ie_ ? OP_NOP : i;
    assign act_s = pend_q & ~mask_q;
    assign v_s   = prio_enc(act_s);
    assign hit_s = (act_s != 8'h00) && (({1'b0, v_s} + 4'd1) > stat_q);

    // Instruction decode, next-state and readback generation.
    always_comb begin
        clrmask_s = 8'h00;
        mask_d    = mask_q;
        stat_d    = stat_q;
        ien_d     = ien_q;
        d_s       = 8'h00;
        d_oe_s    = 1'b0;
        case (op_s)
            OP_NOP:     clrmask_s = 8'h00;
            OP_CLRALL:  clrmask_s = 8'hFF;
            OP_CLRSEL:  clrmask_s = m;
            OP_CLRMSK:  mask_d = 8'h00;
            OP_LDMSK:   mask_d = m;
            OP_SETMSK:  mask_d = mask_q | m;
            OP_CLRBMSK: mask_d = mask_q & ~m;
            OP_LDSTAT:  stat_d = (m[3:0] > 4'd8) ? 4'd8 : m[3:0];
            OP_ACK: begin
                // Acknowledge is gated by the cascade, not by ien.
                if (hit_s && !ei_) begin
                    clrmask_s = onehot(v_s);
                    stat_d    = {1'b0, v_s} + 4'd1;
                end else begin
                    clrmask_s = 8'h00;
                end
            end
            OP_EOI:     stat_d = 4'd0;
            OP_ENA:     ien_d = 1'b1;
            OP_DIS:     ien_d = 1'b0;
            OP_RDMSK: begin
                d_s    = mask_q;
                d_oe_s = 1'b1;
            end
            OP_RDSTAT: begin
                d_s    = {4'b0000, stat_q};
                d_oe_s = 1'b1;
            end
            default:    clrmask_s = 8'h00;
        endcase
        // A new or held request takes precedence over a same-cycle clear.
        pend_d = (pend_q & ~clrmask_s) | set_s;
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 8'h00;
            mask_q <= 8'hFF;
            stat_q <= 4'd0;
            ien_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            stat_q <= stat_d;
            ien_q  <= ien_d;
        end
    end

    assign v    = v_s;
    assign irq_ = ~(hit_s && ien_q && !ei_);
    assign eo_  = ei_ | hit_s;
    assign d    = d_s;
    assign d_oe = d_oe_s;

endmodule

// File: tb/tb_am2914_pic.sv
// Directed scoreboard bench for am2914_pic: stimulus pushes expected outputs, a monitor pops and compares.
module tb_am2914_pic;

    logic       clk;
    logic       rst;
    logic [7:0] p_n;
    logic [3:0] instr;
    logic       ie_n;
    logic [7:0] m_bus;
    logic       ei_n;
    logic       eo_n;
    logic       irq_n;
    logic [2:0] vec;
    logic [7:0] d_out;
    logic       d_oe;

    typedef struct {
        string      name;
        logic       irq;
        logic [2:0] v;
        logic       eo;
        logic [7:0] d;
        logic       doe;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    am2914_pic dut (
        .clk  (clk),
        .rst  (rst),
        .p_   (p_n),
        .i    (instr),
        .ie_  (ie_n),
        .m    (m_bus),
        .ei_  (ei_n),
        .eo_  (eo_n),
        .irq_ (irq_n),
        .v    (vec),
        .d    (d_out),
        .d_oe (d_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge.
    task automatic cyc(input logic r, input logic [7:0] p, input logic [3:0] op,
                       input logic ie, input logic [7:0] mv, input logic ei);
        @(posedge clk);
        #1;
        rst   = r;
        p_n   = p;
        instr = op;
        ie_n  = ie;
        m_bus = mv;
        ei_n  = ei;
    endtask

    task automatic expect_out(input string nm, input logic irq, input logic [2:0] v,
                              input logic eo, input logic [7:0] dv, input logic doe);
        exp_t e;
        e.name = nm;
        e.irq  = irq;
        e.v    = v;
        e.eo   = eo;
        e.d    = dv;
        e.doe  = doe;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every pending expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (irq_n !== e.irq || vec !== e.v || eo_n !== e.eo ||
                    d_out !== e.d || d_oe !== e.doe) begin
                    errors++;
                    $display("FAIL %s: got irq_=%b v=%0d eo_=%b d=%h d_oe=%b, want irq_=%b v=%0d eo_=%b d=%h d_oe=%b",
                             e.name, irq_n, vec, eo_n, d_out, d_oe,
                             e.irq, e.v, e.eo, e.d, e.doe);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        p_n   = 8'h00;
        instr = 4'd0;
        ie_n  = 1'b1;
        m_bus = 8'h00;
        ei_n  = 1'b0;

        // Reset held with all requests asserted.
        cyc(1'b1, 8'h00, 4'd0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h00, 4'd0, 1'b1, 8'h00, 1'b0);
        expect_out("reset",       1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd12, 1'b0, 8'h00, 1'b0);
        expect_out("rst_mask",    1'b1, 3'd0, 1'b0, 8'hFF, 1'b1);
        cyc(1'b0, 8'hFF, 4'd13, 1'b0, 8'h00, 1'b0);
        expect_out("rst_stat",    1'b1, 3'd0, 1'b0, 8'h00, 1'b1);

        // Unmask, enable, requests on lines 5 and 3.
        cyc(1'b0, 8'hD7, 4'd4, 1'b0, 8'h00, 1'b0);
        expect_out("ldmsk",       1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hD7, 4'd10, 1'b0, 8'h00, 1'b0);
        expect_out("pend_noien",  1'b1, 3'd5, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hD7, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("irq_v5",      1'b0, 3'd5, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hF7, 4'd8, 1'b0, 8'h00, 1'b0);
        expect_out("pre_ack5",    1'b0, 3'd5, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hF7, 4'd13, 1'b0, 8'h00, 1'b0);
        expect_out("ack5_stat6",  1'b1, 3'd3, 1'b0, 8'h06, 1'b1);

        // Higher request preempts level 5 service, then stat=8 blocks all.
        cyc(1'b0, 8'h77, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("l3_blocked",  1'b1, 3'd3, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hF7, 4'd8, 1'b0, 8'h00, 1'b0);
        expect_out("irq_v7",      1'b0, 3'd7, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hF7, 4'd13, 1'b0, 8'h00, 1'b0);
        expect_out("stat8_block", 1'b1, 3'd3, 1'b0, 8'h08, 1'b1);
        cyc(1'b0, 8'hF7, 4'd9, 1'b0, 8'h00, 1'b0);
        expect_out("pre_eoi",     1'b1, 3'd3, 1'b0, 8'h00, 1'b0);

        // After EOI line 3 is serviceable; then clear it leaving only line 7.
        cyc(1'b0, 8'h7F, 4'd2, 1'b0, 8'h08, 1'b0);
        expect_out("eoi_v3",      1'b0, 3'd3, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd5, 1'b0, 8'h80, 1'b0);
        expect_out("clrsel_v7",   1'b0, 3'd7, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd12, 1'b0, 8'h00, 1'b0);
        expect_out("setmsk_rd",   1'b1, 3'd0, 1'b0, 8'h80, 1'b1);
        cyc(1'b0, 8'hFF, 4'd6, 1'b0, 8'h80, 1'b0);
        expect_out("clrbmsk",     1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd12, 1'b1, 8'h00, 1'b0);
        expect_out("ie_nop_v7",   1'b0, 3'd7, 1'b1, 8'h00, 1'b0);

        // Cascade disabled: ACK ignored.
        cyc(1'b0, 8'hFF, 4'd8, 1'b0, 8'h00, 1'b1);
        expect_out("ei_hi",       1'b1, 3'd7, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd13, 1'b0, 8'h00, 1'b0);
        expect_out("ack_ignored", 1'b0, 3'd7, 1'b1, 8'h00, 1'b1);

        // ACK still acknowledges with interrupts disabled.
        cyc(1'b0, 8'hFF, 4'd11, 1'b0, 8'h00, 1'b0);
        expect_out("pre_dis",     1'b0, 3'd7, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd8, 1'b0, 8'h00, 1'b0);
        expect_out("dis_irq",     1'b1, 3'd7, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd13, 1'b0, 8'h00, 1'b0);
        expect_out("ack_dis",     1'b1, 3'd0, 1'b0, 8'h08, 1'b1);

        // LDSTAT saturation and exact-level boundary.
        cyc(1'b0, 8'hFF, 4'd7, 1'b0, 8'h0F, 1'b0);
        expect_out("ldstat_f",    1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd13, 1'b0, 8'h00, 1'b0);
        expect_out("stat_sat",    1'b1, 3'd0, 1'b0, 8'h08, 1'b1);
        cyc(1'b0, 8'hFF, 4'd7, 1'b0, 8'h03, 1'b0);
        expect_out("ldstat_3",    1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFB, 4'd13, 1'b0, 8'h00, 1'b0);
        expect_out("stat3",       1'b1, 3'd0, 1'b0, 8'h03, 1'b1);
        cyc(1'b0, 8'hFB, 4'd10, 1'b0, 8'h00, 1'b0);
        expect_out("l2_eq_stat",  1'b1, 3'd2, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFB, 4'd2, 1'b0, 8'h04, 1'b0);
        expect_out("pre_clr2",    1'b1, 3'd2, 1'b0, 8'h00, 1'b0);

        // Held-low line after a clear: level re-sets, edge mode does not.
        cyc(1'b0, 8'hFB, 4'd7, 1'b0, 8'h00, 1'b0);
`ifdef AM2914_EDGE_TRIG_EN
        expect_out("held_clr",    1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFB, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("held_stays0", 1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("release2",    1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFB, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("high2",       1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
`else
        expect_out("held_clr",    1'b1, 3'd2, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFB, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("held_irq",    1'b0, 3'd2, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("release2",    1'b0, 3'd2, 1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'hFB, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("latched2",    1'b0, 3'd2, 1'b1, 8'h00, 1'b0);
`endif
        cyc(1'b0, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0);
        expect_out("fall2",       1'b0, 3'd2, 1'b1, 8'h00, 1'b0);

        // Async reset mid-instruction aborts the load.
        cyc(1'b1, 8'hFF, 4'd4, 1'b0, 8'h0F, 1'b0);
        expect_out("rst_abort",   1'b1, 3'd0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'hFF, 4'd12, 1'b0, 8'h00, 1'b0);
        expect_out("rst_mask2",   1'b1, 3'd0, 1'b0, 8'hFF, 1'b1);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
